aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 153 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES round-sequencing controller.
// Walks a round-iterative AES datapath through load, Nr-1 middle rounds and a
// final round, stalling whenever the key expansion has not yet produced the
// round key for round_idx, then holds the captured result until it is taken.
//
// State table:
//   IDLE  | waiting for a block; in_ready high, cipher frozen
//   LOAD  | request round-0 key; cipher_reset loads in^key when it arrives
//   ROUND | middle rounds 1..Nr-1; cipher advances only when key is valid
//   FINAL | request round-Nr key; capture_en strobes when it arrives
//   HOLD  | result held in output register until out_ready
//
// Optional feature: define AES_ROUND_CTRL_ABORT_EN to add an abort input that
// returns the controller to IDLE from any busy state without capturing.
module aes_round_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] key_len,
  input  logic       dir_in,
  input  logic       key_valid,
  output logic       key_req,
  output logic [3:0] round_idx,
  output logic       cipher_reset,
  output logic       cipher_done,
  output logic       cipher_dir,
  output logic       capture_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
`ifdef AES_ROUND_CTRL_ABORT_EN
  ,
  input  logic       abort
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] klen_q, klen_d;
  logic       dir_q, dir_d;
  logic [3:0] nr;

  // Round count from the latched key length; the reserved code 11 runs as AES-128.
  always_comb begin
    case (klen_q)
      2'b01:   nr = 4'd12;
      2'b10:   nr = 4'd14;
      default: nr = 4'd10;
    endcase
  end

  // State, round counter and per-block configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      klen_q  <= 2'b00;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic and all controller outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    klen_d       = klen_q;
    dir_d        = dir_q;
    in_ready     = 1'b0;
    key_req      = 1'b0;
    round_idx    = 4'd0;
    cipher_reset = 1'b0;
    cipher_done  = 1'b1;
    capture_en   = 1'b0;
    out_valid    = 1'b0;
    busy         = (state_q != S_IDLE);
    cipher_dir   = dir_q;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        cnt_d    = 4'd0;
        if (in_valid) begin
          klen_d  = key_len;
          dir_d   = dir_in;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        key_req = 1'b1;
        if (key_valid) begin
          cipher_reset = 1'b1;
          cnt_d        = 4'd1;
          state_d      = S_ROUND;
        end
      end
      S_ROUND: begin
        key_req   = 1'b1;
        round_idx = cnt_q;
        if (key_valid) begin
          cipher_done = 1'b0;
          cnt_d       = cnt_q + 4'd1;
          // Leave once the last middle round (Nr-1) has been applied.
          if (cnt_d == nr) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        key_req   = 1'b1;
        round_idx = nr;
        if (key_valid) begin
          capture_en = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        round_idx = nr;
        out_valid = 1'b1;
        // in_ready stays low here; it rises only once IDLE is reached.
        if (out_ready) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort outranks key_valid and out_ready: drop the block without capturing.
    if (abort && (state_q != S_IDLE)) begin
      capture_en = 1'b0;
      cnt_d      = 4'd0;
      state_d    = S_IDLE;
    end
`endif
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: cycle-by-cycle expected output vectors
// for AES-128/192/256 blocks, key stalls, result back-pressure, reset
// mid-block and (when AES_ROUND_CTRL_ABORT_EN is defined) abort.
module tb_aes_round_ctrl;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] key_len;
  logic       dir_in;
  logic       key_valid;
  logic       key_req;
  logic [3:0] round_idx;
  logic       cipher_reset;
  logic       cipher_done;
  logic       cipher_dir;
  logic       capture_en;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic       abort;
`endif

  int   checks   = 0;
  int   failures = 0;
  logic last_dir = 1'b0;

  aes_round_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .key_len      (key_len),
    .dir_in       (dir_in),
    .key_valid    (key_valid),
    .key_req      (key_req),
    .round_idx    (round_idx),
    .cipher_reset (cipher_reset),
    .cipher_done  (cipher_done),
    .cipher_dir   (cipher_dir),
    .capture_en   (capture_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy)
`ifdef AES_ROUND_CTRL_ABORT_EN
    ,
    .abort        (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {in_ready, key_req, round_idx, cipher_reset, cipher_done, cipher_dir, capture_en, out_valid, busy}
  logic [11:0] obs;
  assign obs = {in_ready, key_req, round_idx, cipher_reset, cipher_done,
                cipher_dir, capture_en, out_valid, busy};

  function automatic logic [11:0] ov(input logic ir, input logic kr, input logic [3:0] ri,
                                     input logic cr, input logic cd, input logic dr,
                                     input logic ce, input logic ovl, input logic bsy);
    return {ir, kr, ri, cr, cd, dr, ce, ovl, bsy};
  endfunction

  function automatic logic [11:0] idle_v(input logic d);
    return ov(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [11:0] exp);
    #1;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%03h expected=%03h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete block from IDLE back to IDLE.
  task automatic run_block(input logic [1:0] kl, input logic d, input int nr,
                           input int stall_at, input int stall_n, input int fin_stall,
                           input int hold_n, input logic iv_busy);
    in_valid  = 1'b1;
    key_len   = kl;
    dir_in    = d;
    key_valid = 1'b1;
    out_ready = 1'b0;
    chk("idle_accept", idle_v(last_dir));
    tick();
    in_valid = iv_busy;
    dir_in   = ~d;
    key_len  = ~kl;
    chk("load", ov(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, d, 1'b0, 1'b0, 1'b1));
    for (int r = 1; r < nr; r++) begin
      tick();
      if (r == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          key_valid = 1'b0;
          chk("round_stall", ov(1'b0, 1'b1, 4'(r), 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b1));
          tick();
        end
      end
      key_valid = 1'b1;
      chk("round", ov(1'b0, 1'b1, 4'(r), 1'b0, 1'b0, d, 1'b0, 1'b0, 1'b1));
    end
    tick();
    for (int s = 0; s < fin_stall; s++) begin
      key_valid = 1'b0;
      chk("final_stall", ov(1'b0, 1'b1, 4'(nr), 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b1));
      tick();
    end
    key_valid = 1'b1;
    chk("final_capture", ov(1'b0, 1'b1, 4'(nr), 1'b0, 1'b1, d, 1'b1, 1'b0, 1'b1));
    tick();
    for (int h = 0; h < hold_n; h++) begin
      out_ready = 1'b0;
      in_valid  = h[0];
      chk("hold_wait", ov(1'b0, 1'b0, 4'(nr), 1'b0, 1'b1, d, 1'b0, 1'b1, 1'b1));
      tick();
    end
    out_ready = 1'b1;
    in_valid  = iv_busy;
    chk("hold_release", ov(1'b0, 1'b0, 4'(nr), 1'b0, 1'b1, d, 1'b0, 1'b1, 1'b1));
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    last_dir  = d;
    chk("idle_after", idle_v(last_dir));
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    key_len   = 2'b10;
    dir_in    = 1'b1;
    key_valid = 1'b1;
    out_ready = 1'b1;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort     = 1'b0;
`endif
    #2;
    chk("reset_no_clk", idle_v(1'b0));
    tick();
    chk("reset_clocked", idle_v(1'b0));
    reset = 1'b1;
    last_dir = 1'b0;

    // AES-128 encrypt, no stalls, result taken at once (first accept after reset).
    run_block(2'b00, 1'b0, 10, 0, 0, 0, 0, 1'b0);
    // AES-256 decrypt, in_valid held high while busy.
    run_block(2'b10, 1'b1, 14, 0, 0, 0, 0, 1'b1);
    // AES-192, key stall of 3 cycles at round 5, out_ready low for 4 cycles.
    run_block(2'b01, 1'b0, 12, 5, 3, 0, 4, 1'b0);
    // key_len 11 runs as AES-128; key stall in the final round.
    run_block(2'b11, 1'b1, 10, 0, 0, 2, 1, 1'b0);

    // Reset asserted at round 6 discards the block.
    in_valid  = 1'b1;
    key_len   = 2'b00;
    dir_in    = 1'b1;
    key_valid = 1'b1;
    out_ready = 1'b1;
    chk("mid_accept", idle_v(last_dir));
    tick();
    in_valid = 1'b0;
    for (int r = 1; r <= 6; r++) tick();
    chk("mid_round6", ov(1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    reset = 1'b0;
    chk("mid_reset_async", idle_v(1'b0));
    tick();
    chk("mid_reset_edge", idle_v(1'b0));
    reset    = 1'b1;
    last_dir = 1'b0;
    run_block(2'b00, 1'b0, 10, 0, 0, 0, 0, 1'b0);

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort at round 3 beats key_valid.
    in_valid  = 1'b1;
    key_len   = 2'b00;
    dir_in    = 1'b1;
    key_valid = 1'b1;
    out_ready = 1'b1;
    chk("abort_accept", idle_v(last_dir));
    tick();
    in_valid = 1'b0;
    for (int r = 1; r <= 3; r++) tick();
    abort = 1'b1;
    chk("abort_round3", ov(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tick();
    abort    = 1'b0;
    last_dir = 1'b1;
    chk("abort_idle", idle_v(last_dir));

    // Abort in FINAL suppresses capture_en.
    in_valid = 1'b1;
    dir_in   = 1'b0;
    chk("abort2_accept", idle_v(last_dir));
    tick();
    in_valid = 1'b0;
    for (int r = 1; r <= 10; r++) tick();
    abort = 1'b1;
    chk("abort_final", ov(1'b0, 1'b1, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    abort    = 1'b0;
    last_dir = 1'b0;
    chk("abort2_idle", idle_v(last_dir));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
